triangle_raster: RTL

- Sequential rasterizer that feeds the GPU pixel pipeline.
- Accepts one triangle command (three vertices plus a drawing-area clip rectangle) over a valid/ready handshake.
- Walks the clipped bounding box row-major, evaluating one candidate pixel per cycle with an inclusive edge-function test.
- Emits the covered pixel coordinates over a valid/ready stream toward the VRAM writer, then pulses done.

---
 rtl/triangle_raster.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/triangle_raster.sv
// -----------------------------------------------------------------------------
// triangle_raster
//   Sequential triangle rasterizer. Accepts one triangle (three vertices plus an
//   inclusive clip rectangle), walks the clipped bounding box row-major at one
//   candidate pixel per cycle, and streams out the covered pixels. Coverage uses
//   an inclusive edge-function test, so edge pixels are emitted and degenerate
//   triangles produce the pixels lying on their segment (or single point).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   tri_valid / tri_ready    command handshake (ready only while idle)
//   x0..y2                   vertex coordinates, unsigned
//   clip_*                   inclusive drawing area
//   pix_valid / pix_ready    pixel stream handshake
//   pix_x, pix_y             covered pixel coordinate (stable while stalled)
//   busy                     high whenever not idle
//   done                     one-cycle pulse at the end of each triangle
// -----------------------------------------------------------------------------
module triangle_raster #(
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic [COORD_W-1:0] clip_x_min,
  input  logic [COORD_W-1:0] clip_y_min,
  input  logic [COORD_W-1:0] clip_x_max,
  input  logic [COORD_W-1:0] clip_y_max,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               busy,
  output logic               done
);

  // Edge-function width: (COORD_W+1)-bit differences, product plus subtract.
  localparam int EW = 2 * COORD_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  // Latched command
  logic [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
  logic [COORD_W-1:0] cx_min, cy_min, cx_max, cy_max;

  // Clipped bounding box and scan cursor
  logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
  logic [COORD_W-1:0] cur_x, cur_y;

  // SETUP-cycle bounding box (combinational from the latched command)
  logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic [COORD_W-1:0] bb_x_min, bb_x_max, bb_y_min, bb_y_max;
  logic               bb_empty;

  logic signed [EW-1:0] e01, e12, e20;
  logic                 covered;
  logic                 stall;
  logic                 last_pix;

  // Signed edge function of point p against directed edge a->b.
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [COORD_W-1:0] px, py, ax, ay, bx, by
  );
    logic signed [EW-1:0] dpx, dpy, dex, dey;
    dpx = $signed(EW'(px)) - $signed(EW'(ax));
    dpy = $signed(EW'(py)) - $signed(EW'(ay));
    dex = $signed(EW'(bx)) - $signed(EW'(ax));
    dey = $signed(EW'(by)) - $signed(EW'(ay));
    return dpx * dey - dpy * dex;
  endfunction

  always_comb begin
    min_x = vx0;
    max_x = vx0;
    min_y = vy0;
    max_y = vy0;
    if (vx1 < min_x) min_x = vx1;
    if (vx2 < min_x) min_x = vx2;
    if (vx1 > max_x) max_x = vx1;
    if (vx2 > max_x) max_x = vx2;
    if (vy1 < min_y) min_y = vy1;
    if (vy2 < min_y) min_y = vy2;
    if (vy1 > max_y) max_y = vy1;
    if (vy2 > max_y) max_y = vy2;
    bb_x_min = (min_x > cx_min) ? min_x : cx_min;
    bb_x_max = (max_x < cx_max) ? max_x : cx_max;
    bb_y_min = (min_y > cy_min) ? min_y : cy_min;
    bb_y_max = (max_y < cy_max) ? max_y : cy_max;
    bb_empty = (bb_x_min > bb_x_max) || (bb_y_min > bb_y_max);
  end

  always_comb begin
    e01 = edge_fn(cur_x, cur_y, vx0, vy0, vx1, vy1);
    e12 = edge_fn(cur_x, cur_y, vx1, vy1, vx2, vy2);
    e20 = edge_fn(cur_x, cur_y, vx2, vy2, vx0, vy0);
    // Either winding is accepted; zero on any edge counts as inside.
    covered = ((e01 >= 0) && (e12 >= 0) && (e20 >= 0)) ||
              ((e01 <= 0) && (e12 <= 0) && (e20 <= 0));
  end

  assign stall    = pix_valid & ~pix_ready;
  assign last_pix = (cur_x == bx_max) && (cur_y == by_max);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and state-decoded outputs
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_n   = state;
    tri_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        tri_ready = 1'b1;
        busy      = 1'b0;
        if (tri_valid) state_n = S_SETUP;
      end
      S_SETUP: state_n = bb_empty ? S_DONE : S_SCAN;
      S_SCAN:  if (!stall && last_pix) state_n = S_DRAIN;
      S_DRAIN: if (!pix_valid || pix_ready) state_n = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output stage: the only datapath registers with a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else if (state == S_SCAN && !stall) begin
      pix_valid <= covered;
      if (covered) begin
        pix_x <= cur_x;
        pix_y <= cur_y;
      end
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

  // Command, bounding box and cursor registers.
  // NOTE: no reset here; each register is loaded before it is ever used, and
  // the control path above guarantees nothing reads them while idle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && tri_valid) begin
      vx0    <= x0;
      vy0    <= y0;
      vx1    <= x1;
      vy1    <= y1;
      vx2    <= x2;
      vy2    <= y2;
      cx_min <= clip_x_min;
      cy_min <= clip_y_min;
      cx_max <= clip_x_max;
      cy_max <= clip_y_max;
    end
    if (state == S_SETUP) begin
      bx_min <= bb_x_min;
      bx_max <= bb_x_max;
      by_min <= bb_y_min;
      by_max <= bb_y_max;
      cur_x  <= bb_x_min;
      cur_y  <= bb_y_min;
    end
    if (state == S_SCAN && !stall) begin
      if (cur_x == bx_max) begin
        cur_x <= bx_min;
        cur_y <= cur_y + 1'b1;
      end else begin
        cur_x <= cur_x + 1'b1;
      end
    end
  end

endmodule
